// File: rtl/key_operand_builder.sv
// Keypad event qualifier and BCD operand/operator assembler for the calculator ALU.
// Each qualified press on the scanner's ready level becomes exactly one key event.
module key_operand_builder #(
    parameter int DIGITS      = 4,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            tecla,
    input  logic                  ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op_code,
    output logic [4*DIGITS-1:0]   display,
    output logic                  key_pulse,
    output logic                  digit_ovf
);

    // state  | meaning
    // S_A    | entering operand A
    // S_B    | operator chosen, entering operand B
    // S_WAIT | command presented, waiting for ALU handshake
    typedef enum logic [1:0] {S_A, S_B, S_WAIT} state_t;

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int RW = $clog2(HOLD_CYCLES + 1);

    state_t          state, state_nx;
    logic            rdy_q1, rdy_q2, armed;
    logic [RW-1:0]   rel_cnt;
    logic            key_ev;
    logic [CW-1:0]   count_a, count_b, count_a_nx, count_b_nx;
    logic [W-1:0]    a_nx, b_nx;
    logic [1:0]      op_nx;
    logic            valid_nx, ovf_nx;
    logic            is_digit, is_op, is_eq, is_clr;
    logic [3:0]      op_diff;

    assign key_ev   = rdy_q1 & ~rdy_q2 & armed;
    assign is_digit = (tecla <= 4'h9);
    assign is_op    = (tecla >= 4'hA) && (tecla <= 4'hD);
    assign is_eq    = (tecla == 4'hE);
    assign is_clr   = (tecla == 4'hF);
    assign op_diff  = tecla - 4'hA;

    // Release qualification: down-counter reloads while the key is held and
    // re-arms on terminal count after HOLD_CYCLES consecutive released cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q1    <= 1'b0;
            rdy_q2    <= 1'b0;
            armed     <= 1'b1;
            rel_cnt   <= '0;
            key_pulse <= 1'b0;
        end else begin
            rdy_q1    <= ready;
            rdy_q2    <= rdy_q1;
            key_pulse <= key_ev;
            if (rdy_q1)
                rel_cnt <= RW'(HOLD_CYCLES);
            else if (rel_cnt != '0)
                rel_cnt <= rel_cnt - RW'(1);
            if (key_ev)
                armed <= 1'b0;
            else if (!rdy_q1 && rel_cnt == RW'(1))
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            operand_a <= '0;
            operand_b <= '0;
            count_a   <= '0;
            count_b   <= '0;
            op_code   <= 2'b00;
            cmd_valid <= 1'b0;
            digit_ovf <= 1'b0;
        end else begin
            state     <= state_nx;
            operand_a <= a_nx;
            operand_b <= b_nx;
            count_a   <= count_a_nx;
            count_b   <= count_b_nx;
            op_code   <= op_nx;
            cmd_valid <= valid_nx;
            digit_ovf <= ovf_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        a_nx       = operand_a;
        b_nx       = operand_b;
        count_a_nx = count_a;
        count_b_nx = count_b;
        op_nx      = op_code;
        valid_nx   = cmd_valid;
        ovf_nx     = 1'b0;
        case (state)
            S_A: begin
                if (key_ev) begin
                    if (is_digit) begin
                        if (count_a == CW'(DIGITS)) begin
                            ovf_nx = 1'b1;
                        end else begin
                            a_nx       = {operand_a[W-5:0], tecla};
                            count_a_nx = count_a + CW'(1);
                        end
                    end else if (is_op) begin
                        op_nx      = op_diff[1:0];
                        b_nx       = '0;
                        count_b_nx = '0;
                        state_nx   = S_B;
                    end else if (is_clr) begin
                        a_nx       = '0;
                        b_nx       = '0;
                        count_a_nx = '0;
                        count_b_nx = '0;
                        op_nx      = 2'b00;
                    end
                end
            end
            S_B: begin
                if (key_ev) begin
                    if (is_digit) begin
                        if (count_b == CW'(DIGITS)) begin
                            ovf_nx = 1'b1;
                        end else begin
                            b_nx       = {operand_b[W-5:0], tecla};
                            count_b_nx = count_b + CW'(1);
                        end
                    end else if (is_op) begin
                        // Operator may be changed only until B's first digit.
                        if (count_b == '0)
                            op_nx = op_diff[1:0];
                    end else if (is_eq) begin
                        valid_nx = 1'b1;
                        state_nx = S_WAIT;
                    end else if (is_clr) begin
                        a_nx       = '0;
                        b_nx       = '0;
                        count_a_nx = '0;
                        count_b_nx = '0;
                        op_nx      = 2'b00;
                        state_nx   = S_A;
                    end
                end
            end
            S_WAIT: begin
                if (cmd_valid && cmd_ready) begin
                    valid_nx   = 1'b0;
                    a_nx       = '0;
                    b_nx       = '0;
                    count_a_nx = '0;
                    count_b_nx = '0;
                    op_nx      = 2'b00;
                    state_nx   = S_A;
                end
            end
            default: state_nx = S_A;
        endcase
    end

    always_comb begin
        display = operand_a;
        case (state)
            S_B:     display = (count_b != '0) ? operand_b : operand_a;
            S_WAIT:  display = operand_b;
            default: display = operand_a;
        endcase
    end

endmodule

// File: tb/tb_key_operand_builder.sv
// Directed bench for key_operand_builder: decimal-value reference model plus literal checkpoints.
module tb_key_operand_builder;

    localparam int DIGITS = 4;
    localparam int HOLD   = 8;
    localparam int W      = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     tecla = 4'h0;
    logic           ready = 1'b0;
    logic           cmd_ready = 1'b0;
    logic           cmd_valid, key_pulse, digit_ovf;
    logic [W-1:0]   operand_a, operand_b, display;
    logic [1:0]     op_code;

    int n_checks = 0;
    int n_errors = 0;
    int kp_cnt   = 0;
    int ovf_cnt  = 0;

    // reference model state: operands held as plain decimal integers
    int m_a, m_b, m_na, m_nb, m_op, m_mode;
    bit m_valid, m_kp, m_ovf;
    bit m_q1, m_q2, m_armed;
    int m_zrun;

    key_operand_builder #(.DIGITS(DIGITS), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tecla(tecla), .ready(ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
        .display(display), .key_pulse(key_pulse), .digit_ovf(digit_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_mode = 0;
            m_valid = 0; m_kp = 0; m_ovf = 0;
            m_q1 = 0; m_q2 = 0; m_armed = 1; m_zrun = 0;
        end else begin
            bit ev;
            int k;
            ev = m_q1 && !m_q2 && m_armed;
            k = int'(tecla);
            m_kp = ev;
            m_ovf = 0;
            if (m_mode == 2) begin
                if (cmd_ready) begin
                    m_valid = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_mode = 0;
                end
            end else if (ev) begin
                if (k <= 9) begin
                    if (m_mode == 0) begin
                        if (m_na == DIGITS) m_ovf = 1;
                        else begin m_a = m_a * 10 + k; m_na++; end
                    end else begin
                        if (m_nb == DIGITS) m_ovf = 1;
                        else begin m_b = m_b * 10 + k; m_nb++; end
                    end
                end else if (k <= 13) begin
                    if (m_mode == 0) begin
                        m_op = k - 10; m_b = 0; m_nb = 0; m_mode = 1;
                    end else if (m_nb == 0) begin
                        m_op = k - 10;
                    end
                end else if (k == 14) begin
                    if (m_mode == 1) begin m_valid = 1; m_mode = 2; end
                end else begin
                    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_mode = 0;
                end
            end
            if (ev) m_armed = 0;
            if (m_q1) m_zrun = 0;
            else begin
                if (m_zrun < HOLD) m_zrun++;
                if (m_zrun == HOLD) m_armed = 1;
            end
            m_q2 = m_q1;
            m_q1 = ready;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [W-1:0] exp_disp;
            if (m_mode == 0) exp_disp = to_bcd(m_a);
            else if (m_mode == 1) exp_disp = (m_nb > 0) ? to_bcd(m_b) : to_bcd(m_a);
            else exp_disp = to_bcd(m_b);
            check("model_operand_a", 32'(operand_a), 32'(to_bcd(m_a)));
            check("model_operand_b", 32'(operand_b), 32'(to_bcd(m_b)));
            check("model_op_code",   32'(op_code),   32'(m_op));
            check("model_cmd_valid", 32'(cmd_valid), 32'(m_valid));
            check("model_key_pulse", 32'(key_pulse), 32'(m_kp));
            check("model_digit_ovf", 32'(digit_ovf), 32'(m_ovf));
            check("model_display",   32'(display),   32'(exp_disp));
            if (key_pulse) kp_cnt++;
            if (digit_ovf) ovf_cnt++;
        end
    end

    task automatic press(input logic [3:0] key, input int hold = 20, input int low = 10);
        @(negedge clk);
        tecla = key;
        ready = 1'b1;
        repeat (hold) @(negedge clk);
        ready = 1'b0;
        repeat (low - 1) @(negedge clk);
    endtask

    initial begin
        int kp0, ovf0;
        repeat (3) @(negedge clk);
        check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        check("reset_operand_a", 32'(operand_a), 32'h0);
        check("reset_display",   32'(display),   32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 123 - 45 =
        press(4'h1); press(4'h2); press(4'h3); press(4'hB);
        press(4'h4); press(4'h5); press(4'hE);
        check("cmd_operand_a", 32'(operand_a), 32'h0123);
        check("cmd_op_code",   32'(op_code),   32'h1);
        check("cmd_operand_b", 32'(operand_b), 32'h0045);
        check("cmd_valid_set", 32'(cmd_valid), 32'h1);
        check("wait_display",  32'(display),   32'h0045);
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0;
        check("hs_cmd_valid", 32'(cmd_valid), 32'h0);
        check("hs_operand_a", 32'(operand_a), 32'h0);
        check("hs_operand_b", 32'(operand_b), 32'h0);

        // bounce: second ready pulse before release qualification
        kp0 = kp_cnt;
        press(4'h7, 20, 3);
        press(4'h7, 20, 10);
        check("bounce_key_pulses", 32'(kp_cnt - kp0), 32'd1);
        check("bounce_operand_a",  32'(operand_a),    32'h0007);
        press(4'hF);

        // overflow on fifth digit
        ovf0 = ovf_cnt;
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        check("ovf_operand_a", 32'(operand_a),      32'h9876);
        check("ovf_pulses",    32'(ovf_cnt - ovf0), 32'd1);
        press(4'hF);
        check("clear_operand_a", 32'(operand_a), 32'h0);

        // operator overwrite only before B's first digit
        press(4'h1); press(4'hA);
        check("sb_empty_display", 32'(display), 32'h0001);
        press(4'hC);
        check("op_overwrite", 32'(op_code), 32'h2);
        press(4'h3); press(4'hD);
        check("op_locked", 32'(op_code), 32'h2);
        press(4'hE);

        // keys in S_WAIT are consumed but ignored
        kp0 = kp_cnt;
        press(4'hF); press(4'h5);
        check("wait_key_pulses", 32'(kp_cnt - kp0), 32'd2);
        check("wait_cmd_valid",  32'(cmd_valid),    32'h1);
        check("wait_operand_a",  32'(operand_a),    32'h0001);
        check("wait_operand_b",  32'(operand_b),    32'h0003);

        // handshake in the same cycle as a key event
        kp0 = kp_cnt;
        @(negedge clk); tecla = 4'h2; ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0;
        check("hs_ev_cmd_valid", 32'(cmd_valid), 32'h0);
        check("hs_ev_operand_a", 32'(operand_a), 32'h0);
        repeat (18) @(negedge clk);
        ready = 1'b0;
        repeat (9) @(negedge clk);
        check("hs_ev_key_pulse", 32'(kp_cnt - kp0), 32'd1);
        press(4'h6);
        check("after_hs_operand_a", 32'(operand_a), 32'h0006);
        press(4'hF);

        // async reset in S_WAIT
        press(4'h1); press(4'hC); press(4'h2); press(4'hE);
        check("pre_rst_cmd_valid", 32'(cmd_valid), 32'h1);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("arst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("arst_operand_a", 32'(operand_a), 32'h0);
        check("arst_operand_b", 32'(operand_b), 32'h0);
        check("arst_display",   32'(display),   32'h0);
        @(negedge clk); rst_n = 1'b1;
        press(4'h4);
        check("post_rst_operand_a", 32'(operand_a), 32'h0004);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
